ex_muldiv_seq: RTL and testbench

Multi-cycle RV32M multiply/divide sequencer beside the single-cycle ALU in the Execute stage. It accepts one M-extension op from the EX stage and stalls the pipeline while a radix-2 shift-add multiply or restoring divide iterates. It then presents the result for exactly one cycle, where the EX result mux selects it over the ALU result. It owns the iteration counter, the operand/result registers, sign fix-up and flush handling.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/ex_muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Op encodings follow RV32M funct3 so op_i can be cast straight to op_t.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM (not MULHSU).
  function automatic logic op_b_signed(input op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M sequencer: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied as the result is registered.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32   // one step per operand bit; must equal XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            req_valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(ITERS + 1);

  state_t          state_q, state_d;
  op_t             op_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q;     // product high word / partial remainder
  logic [XLEN-1:0] lo_q;     // multiplier bits / dividend bits becoming quotient
  logic            neg_q;    // negate product or quotient
  logic            neg_r_q;  // negate remainder
  logic [XLEN-1:0] res_q;

  // ---------------- request decode (IDLE) ----------------
  op_t             op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign op_in = op_t'(op_i);
  assign a_neg = op_a_signed(op_in) && a_i[XLEN-1];
  assign b_neg = op_b_signed(op_in) && b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // op_i[2] marks divide/remainder, op_i[1] within that selects remainder.
  assign div_zero = op_i[2] && (b_i == '0);
  assign div_ovf  = op_i[2] && !op_i[0] && (a_i == INT_MIN) && (b_i == ALL_ONES);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = op_i[1] ? a_i : ALL_ONES;
    else if (div_ovf) special_res = op_i[1] ? '0  : INT_MIN;
  end

  // ---------------- multiply step ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mul_res;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_nx = mul_sum[XLEN:1];
  assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
  assign prod      = {mul_hi_nx, mul_lo_nx};
  assign prod_fix  = neg_q ? -prod : prod;
  assign mul_res   = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  // ---------------- restoring divide step ----------------
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] rem_nx, quo_nx, div_res;

  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = !div_diff[XLEN];
  assign rem_nx    = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_nx    = {lo_q[XLEN-2:0], div_ge};
  assign div_res   = op_q[1] ? (neg_r_q ? -rem_nx : rem_nx)
                             : (neg_q   ? -quo_nx : quo_nx);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (special)      state_d = DONE;
          else if (op_i[2]) state_d = DIV;
          else              state_d = MUL;
        end
      end
      MUL, DIV: if (cnt_q == CW'(1)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // A redirect kills the op and also blocks acceptance of a new one.
    if (flush_i) state_d = IDLE;
  end

  // ---------------- datapath registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    // NOTE: the operand/result registers are explicitly cleared so a reset
    // mid-operation cannot leak a stale result onto res_o.
    if (!rst_n) begin
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      res_q   <= '0;
    end else if (!flush_i) begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q    <= op_in;
            cnt_q   <= CW'(ITERS);
            opnd_q  <= op_i[2] ? b_mag : a_mag;
            lo_q    <= op_i[2] ? a_mag : b_mag;
            hi_q    <= '0;
            neg_q   <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            if (special) res_q <= special_res;
          end
        end
        MUL: begin
          hi_q  <= mul_hi_nx;
          lo_q  <= mul_lo_nx;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) res_q <= mul_res;
        end
        DIV: begin
          hi_q  <= rem_nx;
          lo_q  <= quo_nx;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) res_q <= div_res;
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign stall_o     = ((state_q == IDLE) && req_valid_i) || (state_q == MUL) || (state_q == DIV);
  assign res_valid_o = (state_q == DONE);
  assign res_o       = res_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: results, latency, special cases, flush, reset.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        req_valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        res_valid_o;
  logic [31:0] res_o;

  int total = 0;
  int bad   = 0;

  localparam int LAT_NORM = 33;  // request cycle + 32 iteration cycles
  localparam int LAT_SPEC = 1;   // request cycle only

  always #5 clk = ~clk;

  ex_muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .stall_o     (stall_o),
    .res_valid_o (res_valid_o),
    .res_o       (res_o)
  );

  // Presents one op from the next negedge, holds it until res_valid_o, and checks
  // result, latency and stall cycles. Returns in the result cycle with req still high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int cyc    = 0;
    int stalls = 0;
    bit seen   = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    op_i = op;
    a_i  = a;
    b_i  = b;
    while (!seen && cyc < 100) begin
      #1;
      if (res_valid_o) seen = 1;
      else begin
        if (stall_o) stalls++;
        @(negedge clk);
        cyc++;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no res_valid_o within %0d cycles", name, cyc);
    end else begin
      total++;
      if (res_o !== exp) begin
        bad++;
        $display("FAIL %s result: got %h expected %h", name, res_o, exp);
      end
      total++;
      if (cyc !== lat) begin
        bad++;
        $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
      end
      total++;
      if (stalls !== lat) begin
        bad++;
        $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, lat);
      end
      total++;
      if (stall_o !== 1'b0) begin
        bad++;
        $display("FAIL %s stall in result cycle: got %b expected 0", name, stall_o);
      end
    end
  endtask

  // Pipeline advances after the result cycle: the result must last exactly one cycle.
  task automatic idle_check(input string name);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    total++;
    if (res_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL %s after result: res_valid=%b stall=%b expected 0/0", name, res_valid_o, stall_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0;
    op_i = 3'd0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (stall_o !== 1'b0 || res_valid_o !== 1'b0 || res_o !== 32'h0) begin
      bad++;
      $display("FAIL reset: stall=%b res_valid=%b res=%h expected 0/0/0", stall_o, res_valid_o, res_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM, "mul_7x-3");
    idle_check("mul_7x-3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORM, "mulhu_max");
    idle_check("mulhu_max");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT_NORM, "mulh_-1x-1");
    idle_check("mulh_-1x-1");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT_NORM, "mulhsu_-1x2");
    idle_check("mulhsu_-1x2");
  endtask

  task automatic test_div();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_NORM, "div_-7/2");
    idle_check("div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_NORM, "rem_-7/2");
    idle_check("rem_-7/2");
    run_op(3'd5, 32'd100,       32'd7, 32'd14,        LAT_NORM, "divu_100/7");
    idle_check("divu_100/7");
    run_op(3'd7, 32'd100,       32'd7, 32'd2,         LAT_NORM, "remu_100/7");
    idle_check("remu_100/7");
  endtask

  task automatic test_special();
    run_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPEC, "div_by_zero");
    idle_check("div_by_zero");
    run_op(3'd7, 32'd5,         32'd0,         32'd5,         LAT_SPEC, "remu_by_zero");
    idle_check("remu_by_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC, "div_overflow");
    idle_check("div_overflow");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_SPEC, "rem_overflow");
    idle_check("rem_overflow");
  endtask

  task automatic test_flush();
    bit got = 0;
    @(negedge clk);
    req_valid_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++;
      $display("FAIL flush pre: stall=%b expected 1", stall_o);
    end
    flush_i = 1'b1;
    req_valid_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0 || res_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush post: stall=%b res_valid=%b expected 0/0", stall_o, res_valid_o);
    end
    repeat (40) begin
      @(negedge clk);
      #1;
      if (res_valid_o) got = 1;
    end
    total++;
    if (got) begin
      bad++;
      $display("FAIL flush killed op: res_valid seen=1 expected 0");
    end
    run_op(3'd0, 32'd3, 32'd4, 32'd12, LAT_NORM, "mul_after_flush");
    idle_check("mul_after_flush");
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    @(negedge clk);
    req_valid_i = 1'b1; op_i = 3'd0; a_i = 32'd5; b_i = 32'd9;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (stall_o !== 1'b0 || res_valid_o !== 1'b0 || res_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: stall=%b res_valid=%b res=%h expected 0/0/0", stall_o, res_valid_o, res_o);
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (res_valid_o) got = 1;
    end
    total++;
    if (got) begin
      bad++;
      $display("FAIL reset_mid discarded op: res_valid seen=1 expected 0");
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'd6,   32'd7,         32'd42,        LAT_NORM, "b2b_mul");
    run_op(3'd4, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFDF, LAT_NORM, "b2b_div");
    run_op(3'd4, 32'd9,   32'd0,         32'hFFFF_FFFF, LAT_SPEC, "b2b_div0");
    idle_check("b2b");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
